// File: rtl/tt_ctrl_sel.sv
// tt_ctrl_sel: pad-side project select controller.
// Syncs and filters ctrl pads, counts sel_inc edges.
module tt_ctrl_sel #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned ADDR_MAX = 1023,
  parameter int unsigned FILT     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_ctrl_ena,
  input  logic              pad_ctrl_sel_inc,
  input  logic              pad_ctrl_sel_rst_n,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_ena,
  output logic              sel_busy,
  output logic              sel_ign
);

  localparam int ENA = 0;
  localparam int INC = 1;
  localparam int CLR = 2;

  localparam logic [3:0] CNT_LIM = 4'(FILT - 1);
  localparam logic [ADDR_W-1:0] AMAX =
    ADDR_W'(ADDR_MAX);

  typedef enum logic [1:0] {
    A_HOLD,
    A_CLEAR,
    A_COUNT,
    A_FROZEN
  } act_e;

  logic [2:0]      pad;
  logic [2:0]      sy1_q;
  logic [2:0]      sy2_q;
  logic [2:0]      f_q;
  logic [2:0]      f_d;
  logic [2:0][3:0] cnt_q;
  logic [2:0][3:0] cnt_d;

  logic              inc_d_q;
  logic              inc_pulse;
  act_e              act;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              ign_q;
  logic              ign_d;
  logic              ena_q;
  logic              busy_q;

  assign pad = {pad_ctrl_sel_rst_n,
                pad_ctrl_sel_inc,
                pad_ctrl_ena};

  // All filtered levels reset low: sel_rst_n
  // starts asserted, holding the address at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1_q <= '0;
      sy2_q <= '0;
      f_q   <= '0;
      cnt_q <= '0;
    end else begin
      sy1_q <= pad;
      sy2_q <= sy1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sy2_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LIM) begin
        f_d[i]   = sy2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  assign inc_pulse = f_q[INC] & ~inc_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_d_q <= 1'b0;
      addr_q  <= '0;
      ign_q   <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      inc_d_q <= f_q[INC];
      addr_q  <= addr_d;
      ign_q   <= ign_d;
      ena_q   <= f_q[ENA];
      busy_q  <= ~f_q[CLR];
    end
  end

  always_comb begin
    act = A_HOLD;
    unique case (1'b1)
      !f_q[CLR]:
        act = A_CLEAR;
      f_q[CLR] && inc_pulse && !f_q[ENA]:
        act = A_COUNT;
      f_q[CLR] && inc_pulse && f_q[ENA]:
        act = A_FROZEN;
      default:
        act = A_HOLD;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    ign_d  = ign_q;
    unique case (act)
      A_CLEAR: begin
        addr_d = '0;
        ign_d  = 1'b0;
      end
      A_COUNT: begin
        if (addr_q == AMAX) addr_d = '0;
        else addr_d = addr_q + ADDR_W'(1);
      end
      A_FROZEN: ign_d = 1'b1;
      default: ;
    endcase
  end

  assign sel_addr = addr_q;
  assign sel_ena  = ena_q;
  assign sel_busy = busy_q;
  assign sel_ign  = ign_q;

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// tb_tt_ctrl_sel: directed bench for tt_ctrl_sel.
// Instance b uses ADDR_MAX=3 to cover wrap.
module tb_tt_ctrl_sel;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       inc;
  logic       srn;
  logic [9:0] a_addr;
  logic       a_ena;
  logic       a_busy;
  logic       a_ign;
  logic [2:0] b_addr;
  logic       b_ena;
  logic       b_busy;
  logic       b_ign;

  int n_cmp;
  int n_bad;

  tt_ctrl_sel dut_a (
    .clk                (clk),
    .rst_n              (rst_n),
    .pad_ctrl_ena       (ena),
    .pad_ctrl_sel_inc   (inc),
    .pad_ctrl_sel_rst_n (srn),
    .sel_addr           (a_addr),
    .sel_ena            (a_ena),
    .sel_busy           (a_busy),
    .sel_ign            (a_ign)
  );

  tt_ctrl_sel #(
    .ADDR_W   (3),
    .ADDR_MAX (3),
    .FILT     (3)
  ) dut_b (
    .clk                (clk),
    .rst_n              (rst_n),
    .pad_ctrl_ena       (ena),
    .pad_ctrl_sel_inc   (inc),
    .pad_ctrl_sel_rst_n (srn),
    .sel_addr           (b_addr),
    .sel_ena            (b_ena),
    .sel_busy           (b_busy),
    .sel_ign            (b_ign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    inc = 1'b1;
    step(hi);
    inc = 1'b0;
    step(lo);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    inc   = 1'b1;
    srn   = 1'b1;

    // reset values with all pads high
    step(2);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_ena", 32'(a_ena), 0);
    chk("rst_busy", 32'(a_busy), 1);
    chk("rst_ign", 32'(a_ign), 0);
    chk("rst_b_busy", 32'(b_busy), 1);

    // release: outputs move at edge 2+FILT+1
    rst_n = 1'b1;
    step(5);
    chk("rel5_busy", 32'(a_busy), 1);
    chk("rel5_ena", 32'(a_ena), 0);
    step(1);
    chk("rel6_busy", 32'(a_busy), 0);
    chk("rel6_ena", 32'(a_ena), 1);
    chk("rel6_ign", 32'(a_ign), 1);
    chk("rel6_addr", 32'(a_addr), 0);
    chk("rel6_b_ign", 32'(b_ign), 1);

    srn = 1'b0;
    ena = 1'b0;
    inc = 1'b0;
    step(8);
    chk("clr_busy", 32'(a_busy), 1);
    chk("clr_ign", 32'(a_ign), 0);
    chk("clr_ena", 32'(a_ena), 0);
    srn = 1'b1;
    step(8);
    chk("run_busy", 32'(a_busy), 0);

    // counting, exact latency per pulse
    for (int k = 1; k <= 5; k++) begin
      inc = 1'b1;
      step(5);
      chk("cnt_pre_a", 32'(a_addr), 32'(k - 1));
      chk("cnt_pre_b", 32'(b_addr),
          32'((k - 1) % 4));
      step(1);
      chk("cnt_a", 32'(a_addr), 32'(k));
      chk("cnt_b", 32'(b_addr), 32'(k % 4));
      step(2);
      inc = 1'b0;
      step(8);
    end

    // glitch rejection
    pulse(2, 10);
    chk("glitch2_a", 32'(a_addr), 5);
    chk("glitch2_b", 32'(b_addr), 1);
    pulse(3, 10);
    chk("pulse3_a", 32'(a_addr), 6);
    chk("pulse3_b", 32'(b_addr), 2);

    // run mode, enable low-glitch
    ena = 1'b1;
    step(8);
    chk("run_ena", 32'(a_ena), 1);
    ena = 1'b0;
    step(2);
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("ena_glitch", 32'(a_ena), 1);
    end

    // frozen increments
    pulse(8, 8);
    pulse(8, 8);
    pulse(8, 8);
    chk("frz_a", 32'(a_addr), 6);
    chk("frz_b", 32'(b_addr), 2);
    chk("frz_ign", 32'(a_ign), 1);
    srn = 1'b0;
    step(8);
    chk("frzclr_a", 32'(a_addr), 0);
    chk("frzclr_b", 32'(b_addr), 0);
    chk("frzclr_ign", 32'(a_ign), 0);
    chk("frzclr_busy", 32'(a_busy), 1);
    ena = 1'b0;
    srn = 1'b1;
    step(8);
    chk("idle_ena", 32'(a_ena), 0);
    chk("idle_busy", 32'(a_busy), 0);

    // clear and increment filtered together
    pulse(8, 8);
    chk("pri_pre", 32'(a_addr), 1);
    inc = 1'b1;
    srn = 1'b0;
    step(5);
    chk("pri5", 32'(a_addr), 1);
    step(1);
    chk("pri6_a", 32'(a_addr), 0);
    chk("pri6_b", 32'(b_addr), 0);
    chk("pri6_busy", 32'(a_busy), 1);
    inc = 1'b0;
    step(8);
    srn = 1'b1;
    step(8);

    // async reset mid-count
    pulse(8, 8);
    pulse(8, 8);
    chk("mid_a", 32'(a_addr), 2);
    chk("mid_b", 32'(b_addr), 2);
    ena = 1'b1;
    step(8);
    chk("mid_ena", 32'(a_ena), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a", 32'(a_addr), 0);
    chk("async_b", 32'(b_addr), 0);
    chk("async_ena", 32'(a_ena), 0);
    chk("async_busy", 32'(a_busy), 1);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("rebuild_busy", 32'(a_busy), 0);
    chk("rebuild_ena", 32'(a_ena), 1);
    chk("rebuild_a", 32'(a_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
